// File: rtl/avm_rd_arbiter.sv
// ---------------------------------------------------------------------------
// avm_rd_arbiter
//
// Round-robin arbiter that merges NREQ Avalon-MM read-only requesters onto a
// single 16-bit Avalon-MM read master. The requester id of every accepted read
// is pushed into a tag FIFO. Read data returns in issue order, so the head of
// the FIFO tells which requester owns each returned word.
//
// Parameters
//   NREQ      number of read requesters (2..4)
//   TAGDEPTH  maximum number of accepted, not yet returned reads (power of 2)
//
// Ports
//   clk                   single clock, rising edge
//   reset                 asynchronous, active-low reset
//   s_read[NREQ]          per-requester read request
//   s_address[32*NREQ]    per-requester address, slice i = [32*i +: 32]
//   s_waitrequest[NREQ]   per-requester stall (0 only for the accepted id)
//   s_readdata[16]        returned word, shared by all requesters
//   s_readdatavalid[NREQ] one-hot return strobe
//   avm_m0_*              shared read master (write side tied off)
//   err                   sticky: a return arrived with no outstanding read
// ---------------------------------------------------------------------------
module avm_rd_arbiter #(
    parameter int NREQ     = 2,
    parameter int TAGDEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      s_read,
    input  logic [32*NREQ-1:0]   s_address,
    output logic [NREQ-1:0]      s_waitrequest,
    output logic [15:0]          s_readdata,
    output logic [NREQ-1:0]      s_readdatavalid,
    output logic                 avm_m0_read,
    output logic                 avm_m0_write,
    output logic [15:0]          avm_m0_writedata,
    output logic [31:0]          avm_m0_address,
    output logic [1:0]           avm_m0_byteenable,
    input  logic [15:0]          avm_m0_readdata,
    input  logic                 avm_m0_readdatavalid,
    input  logic                 avm_m0_waitrequest,
    output logic                 err
);

    localparam int ID_W  = (NREQ > 2) ? 2 : 1;
    localparam int PTR_W = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Arbitration state
    logic [ID_W-1:0]  rr;
    logic             lock;
    logic [ID_W-1:0]  lock_id;
    logic [ID_W-1:0]  rr_grant;
    logic [ID_W-1:0]  grant;

    // Tag FIFO state
    logic [ID_W-1:0]  tag_mem [TAGDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [ID_W-1:0]  head_id;

    logic             issue;
    logic             accept;
    logic             pop;

    assign avm_m0_write      = 1'b0;
    assign avm_m0_writedata  = 16'h0000;
    assign avm_m0_byteenable = 2'b11;

    assign full    = (count == CNT_W'(TAGDEPTH));
    assign empty   = (count == '0);
    assign head_id = tag_mem[rd_ptr];

    // Round-robin search: first requesting id starting at rr, wrapping at NREQ.
    // NOTE: every signal written in an always_comb gets a default at the top;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        logic found;
        int   idx;
        rr_grant = rr;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && s_read[idx]) begin
                found    = 1'b1;
                rr_grant = ID_W'(idx);
            end
        end
    end

    // A stalled request keeps its grant until the memory takes it, so the
    // address never changes under an asserted waitrequest.
    assign grant = lock ? lock_id : rr_grant;

    // Issue is held off whenever the FIFO is full, even if a pop is in flight
    // this cycle; the freed slot is used from the next cycle on.
    assign issue  = reset & (|s_read) & ~full;
    assign accept = issue & ~avm_m0_waitrequest;
    assign pop    = reset & avm_m0_readdatavalid & ~empty;

    assign avm_m0_read    = issue;
    assign avm_m0_address = s_address[32*grant +: 32];

    always_comb begin
        s_waitrequest   = '1;
        s_readdatavalid = '0;
        s_readdata      = 16'h0000;
        if (accept) begin
            s_waitrequest[grant] = 1'b0;
        end
        if (pop) begin
            s_readdatavalid[head_id] = 1'b1;
            s_readdata               = avm_m0_readdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr      <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                rr   <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
                lock <= 1'b0;
            end else if (issue && avm_m0_waitrequest) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (avm_m0_readdatavalid && empty) begin
                err <= 1'b1;
            end
        end
    end

    // NOTE: the tag storage has no reset; entries are only read between a
    // push and its pop, and clearing the pointers makes stale contents dead.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_avm_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avm_rd_arbiter
//
// Directed bench for avm_rd_arbiter (NREQ=2, TAGDEPTH=8). Inputs change on
// the falling clock edge, outputs are compared 1 ns later, and the rising
// edge commits. Requester 0 drives address 0x10 and requester 1 drives 0x20.
// ---------------------------------------------------------------------------
module tb_avm_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_read;
    logic [63:0] s_address;
    logic [1:0]  s_waitrequest;
    logic [15:0] s_readdata;
    logic [1:0]  s_readdatavalid;
    logic        avm_m0_read;
    logic        avm_m0_write;
    logic [15:0] avm_m0_writedata;
    logic [31:0] avm_m0_address;
    logic [1:0]  avm_m0_byteenable;
    logic [15:0] avm_m0_readdata;
    logic        avm_m0_readdatavalid;
    logic        avm_m0_waitrequest;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] ADDR0 = 32'h0000_0010;
    localparam logic [31:0] ADDR1 = 32'h0000_0020;

    always #5 clk = ~clk;

    avm_rd_arbiter #(.NREQ(2), .TAGDEPTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .s_read               (s_read),
        .s_address            (s_address),
        .s_waitrequest        (s_waitrequest),
        .s_readdata           (s_readdata),
        .s_readdatavalid      (s_readdatavalid),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .err                  (err)
    );

    // Move to the next falling edge and park all inputs at idle.
    task automatic idle_cycle();
        @(negedge clk);
        s_read               = 2'b00;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata      = 16'h0000;
        avm_m0_waitrequest   = 1'b0;
    endtask

    // One-cycle reset pulse; leaves reset released at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset                = 1'b0;
        s_read               = 2'b00;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_waitrequest   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset                = 1'b0;
        s_read               = 2'b11;
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = 16'hbeef;
        avm_m0_waitrequest   = 1'b0;
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b0) begin
            n_fail++; $display("FAIL reset_read: got %b expected 0", avm_m0_read);
        end
        n_tests++;
        if (s_waitrequest !== 2'b11) begin
            n_fail++; $display("FAIL reset_waitreq: got %b expected 11", s_waitrequest);
        end
        n_tests++;
        if (s_readdatavalid !== 2'b00 || s_readdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_return: got rdv=%b data=%h expected 00/0000",
                               s_readdatavalid, s_readdata);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", err);
        end
        n_tests++;
        if (avm_m0_write !== 1'b0 || avm_m0_writedata !== 16'h0000 || avm_m0_byteenable !== 2'b11) begin
            n_fail++; $display("FAIL tieoffs: got wr=%b wd=%h be=%b expected 0/0000/11",
                               avm_m0_write, avm_m0_writedata, avm_m0_byteenable);
        end
        idle_cycle();
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        s_read = 2'b01;
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b1 || avm_m0_address !== ADDR0 || s_waitrequest !== 2'b10) begin
            n_fail++; $display("FAIL single_issue: got rd=%b addr=%h wr=%b expected 1/%h/10",
                               avm_m0_read, avm_m0_address, s_waitrequest, ADDR0);
        end
        idle_cycle();
        idle_cycle();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = 16'h000a;
        #1;
        n_tests++;
        if (s_readdatavalid !== 2'b01 || s_readdata !== 16'h000a) begin
            n_fail++; $display("FAIL single_return: got rdv=%b data=%h expected 01/000a",
                               s_readdatavalid, s_readdata);
        end
        idle_cycle();
        #1;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL single_err: got %b expected 0", err);
        end
    endtask

    task automatic test_fairness();
        logic [1:0]  exp_wr [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [31:0] exp_ad [4] = '{ADDR0, ADDR1, ADDR0, ADDR1};
        logic [1:0]  exp_rv [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_read = 2'b11;
            #1;
            n_tests++;
            if (avm_m0_address !== exp_ad[i] || s_waitrequest !== exp_wr[i]) begin
                n_fail++; $display("FAIL fair_grant%0d: got addr=%h wr=%b expected %h/%b",
                                   i, avm_m0_address, s_waitrequest, exp_ad[i], exp_wr[i]);
            end
            @(negedge clk);
        end
        s_read = 2'b00;
        for (int i = 0; i < 4; i++) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = 16'(i + 1);
            #1;
            n_tests++;
            if (s_readdatavalid !== exp_rv[i] || s_readdata !== 16'(i + 1)) begin
                n_fail++; $display("FAIL fair_return%0d: got rdv=%b data=%h expected %b/%h",
                                   i, s_readdatavalid, s_readdata, exp_rv[i], 16'(i + 1));
            end
            @(negedge clk);
        end
        avm_m0_readdatavalid = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        // One accepted read from requester 0 moves rr to 1, so an unlocked
        // arbiter would switch to requester 1 as soon as it asks.
        s_read = 2'b01;
        @(negedge clk);
        avm_m0_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            s_read = (c == 2) ? 2'b11 : 2'b01;
            #1;
            n_tests++;
            if (avm_m0_read !== 1'b1 || avm_m0_address !== ADDR0 || s_waitrequest !== 2'b11) begin
                n_fail++; $display("FAIL lock_stall%0d: got rd=%b addr=%h wr=%b expected 1/%h/11",
                                   c, avm_m0_read, avm_m0_address, s_waitrequest, ADDR0);
            end
            @(negedge clk);
        end
        avm_m0_waitrequest = 1'b0;
        s_read             = 2'b11;
        #1;
        n_tests++;
        if (avm_m0_address !== ADDR0 || s_waitrequest !== 2'b10) begin
            n_fail++; $display("FAIL lock_accept: got addr=%h wr=%b expected %h/10",
                               avm_m0_address, s_waitrequest, ADDR0);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (avm_m0_address !== ADDR1 || s_waitrequest !== 2'b01) begin
            n_fail++; $display("FAIL lock_next: got addr=%h wr=%b expected %h/01",
                               avm_m0_address, s_waitrequest, ADDR1);
        end
        idle_cycle();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_read = 2'b01;
            #1;
            n_tests++;
            if (avm_m0_read !== 1'b1 || s_waitrequest !== 2'b10) begin
                n_fail++; $display("FAIL full_fill%0d: got rd=%b wr=%b expected 1/10",
                                   i, avm_m0_read, s_waitrequest);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b0 || s_waitrequest !== 2'b11) begin
            n_fail++; $display("FAIL full_block: got rd=%b wr=%b expected 0/11",
                               avm_m0_read, s_waitrequest);
        end
        @(negedge clk);
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = 16'h0055;
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b0 || s_readdatavalid !== 2'b01 || s_readdata !== 16'h0055) begin
            n_fail++; $display("FAIL full_pop: got rd=%b rdv=%b data=%h expected 0/01/0055",
                               avm_m0_read, s_readdatavalid, s_readdata);
        end
        @(negedge clk);
        avm_m0_readdatavalid = 1'b0;
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b1 || s_waitrequest !== 2'b10) begin
            n_fail++; $display("FAIL full_resume: got rd=%b wr=%b expected 1/10",
                               avm_m0_read, s_waitrequest);
        end
        idle_cycle();
    endtask

    task automatic test_spurious();
        do_reset();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata      = 16'h1234;
        #1;
        n_tests++;
        if (s_readdatavalid !== 2'b00) begin
            n_fail++; $display("FAIL spur_rdv: got %b expected 00", s_readdatavalid);
        end
        idle_cycle();
        idle_cycle();
        idle_cycle();
        #1;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL spur_err_sticky: got %b expected 1", err);
        end
        do_reset();
        #1;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL spur_err_clear: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        // Three accepts (0, 1, 0) leave rr at 1 and three tags outstanding.
        for (int i = 0; i < 3; i++) begin
            s_read = 2'b11;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (avm_m0_read !== 1'b0 || s_waitrequest !== 2'b11 || s_readdatavalid !== 2'b00 || err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outs: got rd=%b wr=%b rdv=%b err=%b expected 0/11/00/0",
                               avm_m0_read, s_waitrequest, s_readdatavalid, err);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (avm_m0_address !== ADDR0 || s_waitrequest !== 2'b10) begin
            n_fail++; $display("FAIL mid_rr_cleared: got addr=%h wr=%b expected %h/10",
                               avm_m0_address, s_waitrequest, ADDR0);
        end
        @(negedge clk);
        s_read = 2'b00;
        // Drain the one read just issued, then a stale return must flag err.
        avm_m0_readdatavalid = 1'b1;
        #1;
        n_tests++;
        if (s_readdatavalid !== 2'b01) begin
            n_fail++; $display("FAIL mid_own_return: got %b expected 01", s_readdatavalid);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (s_readdatavalid !== 2'b00) begin
            n_fail++; $display("FAIL mid_stale_rdv: got %b expected 00", s_readdatavalid);
        end
        idle_cycle();
        #1;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL mid_stale_err: got %b expected 1", err);
        end
    endtask

    initial begin
        reset                = 1'b0;
        s_read               = 2'b00;
        s_address            = {ADDR1, ADDR0};
        avm_m0_readdata      = 16'h0000;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_waitrequest   = 1'b0;

        test_reset();
        test_single_read();
        test_fairness();
        test_lock();
        test_full();
        test_spurious();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
